// File: rtl/whack_input_handler_if.sv
// Signal bundle between the switch bank / mole handler and the scoring block.
// The DUT takes the slave view; the driving environment takes the master view.
interface whack_input_handler_if;
  logic        enable_i;
  logic [15:0] switches_i;
  logic [15:0] moles_i;
  logic        whacked_o;
  logic        missed_o;
  logic [3:0]  hit_index_o;
  logic [15:0] claimed_o;
  logic [7:0]  miss_count_o;

  modport master (
    output enable_i, switches_i, moles_i,
    input  whacked_o, missed_o, hit_index_o, claimed_o, miss_count_o
  );

  modport slave (
    input  enable_i, switches_i, moles_i,
    output whacked_o, missed_o, hit_index_o, claimed_o, miss_count_o
  );
endinterface

// File: rtl/whack_input_handler.sv
// Debounces the switch bank and resolves flips against lit moles into whack/miss pulses.
// Optional saturating miss counter enabled by defining WHACK_MISS_COUNT_EN.
module whack_input_handler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int N_MOLES         = 16
) (
  input logic                  clock_i,
  input logic                  reset_i,
  whack_input_handler_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      presc_reg;
  logic               tick;
  logic [N_MOLES-1:0] sync1_reg, sync_reg, samp_reg;
  logic [N_MOLES-1:0] deb_reg, deb_next, deb_d_reg;
  logic [N_MOLES-1:0] flip, hits, miss;
  logic [N_MOLES-1:0] claimed_reg, claimed_next;
  logic               whacked_reg, whacked_next;
  logic               missed_reg, missed_next;
  logic [3:0]         hit_index_reg, hit_index_next, lowest_hit;

  assign tick = (presc_reg == CW'(DEBOUNCE_CYCLES - 1));

  // A bit only moves when two consecutive tick samples agree.
  generate
    for (genvar gi = 0; gi < N_MOLES; gi++) begin : g_deb
      assign deb_next[gi] = (tick && (sync_reg[gi] == samp_reg[gi])) ? sync_reg[gi]
                                                                      : deb_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_reg <= '0;
      sync_reg  <= '0;
      presc_reg <= '0;
      samp_reg  <= '0;
      deb_reg   <= '0;
      deb_d_reg <= '0;
    end else begin
      sync1_reg <= bus.switches_i;
      sync_reg  <= sync1_reg;
      presc_reg <= tick ? '0 : presc_reg + CW'(1);
      if (tick) samp_reg <= sync_reg;
      deb_reg   <= deb_next;
      deb_d_reg <= deb_reg;
    end
  end

  assign flip = deb_reg ^ deb_d_reg;
  // Events only resolve while the game is both running and still enabled.
  assign hits = (state_reg == ACTIVE && bus.enable_i) ? (flip & bus.moles_i & ~claimed_reg) : '0;
  assign miss = (state_reg == ACTIVE && bus.enable_i) ? (flip & ~bus.moles_i) : '0;

  always_comb begin
    lowest_hit = '0;
    for (int i = N_MOLES - 1; i >= 0; i--) begin
      if (hits[i]) lowest_hit = 4'(i);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      claimed_reg   <= '0;
      whacked_reg   <= 1'b0;
      missed_reg    <= 1'b0;
      hit_index_reg <= '0;
    end else begin
      state_reg     <= state_next;
      claimed_reg   <= claimed_next;
      whacked_reg   <= whacked_next;
      missed_reg    <= missed_next;
      hit_index_reg <= hit_index_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    claimed_next   = '0;
    whacked_next   = 1'b0;
    missed_next    = 1'b0;
    hit_index_next = hit_index_reg;
    case (state_reg)
      IDLE: begin
        if (bus.enable_i) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!bus.enable_i) state_next = IDLE;
        // Masking by moles_i lets an unlit mole drop its claim before any new claim lands.
        claimed_next = (claimed_reg | hits) & bus.moles_i;
        if (|hits) begin
          whacked_next   = 1'b1;
          hit_index_next = lowest_hit;
        end else if (|miss) begin
          missed_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.whacked_o   = whacked_reg;
  assign bus.missed_o    = missed_reg;
  assign bus.hit_index_o = hit_index_reg;
  assign bus.claimed_o   = claimed_reg;

`ifdef WHACK_MISS_COUNT_EN
  logic [7:0] miss_count_reg;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      miss_count_reg <= '0;
    end else if (missed_next && (miss_count_reg != 8'hFF)) begin
      miss_count_reg <= miss_count_reg + 8'd1;
    end
  end

  assign bus.miss_count_o = miss_count_reg;
`else
  assign bus.miss_count_o = 8'h00;
`endif

endmodule
